// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART-side system controller: command codes,
// FSM state encoding and the frame-timeout counter sizing helper.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR       = 8'hAA;
    localparam logic [7:0] CMD_RD       = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
    localparam logic [7:0] CMD_BURST_WR = 8'hEE;
    localparam logic [7:0] CMD_BURST_RD = 8'hEF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_CNT,
        S_GET_DATA,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_RD_REQ,
        S_RD_WAIT,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI
    } state_e;

    typedef enum logic [2:0] {
        OP_WR,
        OP_RD,
        OP_ALU,
        OP_BWR,
        OP_BRD
    } op_e;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_slot.sv
// One-entry transmit holding register. TX_D_VLD stays high with stable data
// until a cycle in which busy_i is low; that cycle is the transfer.
module sys_ctrl_tx_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  busy_i,
    output logic                  accepted_o,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_vld_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && !busy_i) begin
            valid_q <= 1'b0;
        end
    end

    assign accepted_o = valid_q && !busy_i;
    assign full_o     = valid_q;
    assign tx_data_o  = data_q;
    assign tx_vld_o   = valid_q;

endmodule

// File: rtl/sys_ctrl_burst.sv
// UART-side system controller: decodes RX command frames into register-file
// and ALU operations (single and burst) and returns results through TX.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]  ALU_OUT,
    input  logic                     OUT_VALID,
    input  logic                     Busy,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_EN,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     WrEN,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     RdEN,
    output logic                     clk_div_en,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     frame_err
);

    localparam int            TW      = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    state_e                   state_q;
    op_e                      op_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0]    alu_hi_q;
    logic [TW-1:0]            tmo_q;
    logic                     hi_sent_q;

    logic                     wr_en_q, rd_en_q, alu_en_q, clk_en_q;
    logic                     clk_div_en_q, frame_err_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [FUN_WIDTH-1:0]     alu_fun_q;

    logic                     in_get, tmo_hit, drop_byte;
    logic                     tx_load, tx_accepted, tx_full;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic [ADDRESS_WIDTH-1:0] rx_addr;

    function automatic logic is_cmd(input logic [DATA_WIDTH-1:0] b, input logic [7:0] code);
        return b == DATA_WIDTH'(code);
    endfunction

    assign rx_addr = RX_P_DATA[ADDRESS_WIDTH-1:0];
    assign addr_d  = addr_q + ADDRESS_WIDTH'(1);

    always_comb begin
        in_get    = state_q inside {S_GET_ADDR, S_GET_CNT, S_GET_DATA, S_GET_A, S_GET_B, S_GET_FUN};
        tmo_hit   = in_get && !RX_D_VLD && (tmo_q == TMO_MAX);
        drop_byte = RX_D_VLD && (state_q inside {S_RD_REQ, S_RD_WAIT, S_ALU_WAIT, S_TX_LO, S_TX_HI});
    end

    // The high ALU byte is only offered once the line is idle again.
    always_comb begin
        tx_load = 1'b0;
        tx_data = '0;
        case (state_q)
            S_RD_WAIT: begin
                tx_load = RdData_Valid;
                tx_data = RdData;
            end
            S_ALU_WAIT: begin
                tx_load = OUT_VALID;
                tx_data = ALU_OUT[DATA_WIDTH-1:0];
            end
            S_TX_HI: begin
                tx_load = !hi_sent_q && !tx_full && !Busy;
                tx_data = alu_hi_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_WR;
            addr_q       <= '0;
            cnt_q        <= '0;
            alu_hi_q     <= '0;
            tmo_q        <= '0;
            hi_sent_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            clk_en_q     <= 1'b0;
            clk_div_en_q <= 1'b0;
            frame_err_q  <= 1'b0;
            address_q    <= '0;
            wr_data_q    <= '0;
            alu_fun_q    <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            clk_div_en_q <= 1'b1;
            frame_err_q  <= tmo_hit || drop_byte;
            tmo_q        <= (!in_get || RX_D_VLD || tmo_hit) ? '0 : tmo_q + TW'(1);

            if (tmo_hit) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (RX_D_VLD) begin
                        if (is_cmd(RX_P_DATA, CMD_WR)) begin
                            op_q <= OP_WR;  state_q <= S_GET_ADDR;
                        end else if (is_cmd(RX_P_DATA, CMD_RD)) begin
                            op_q <= OP_RD;  state_q <= S_GET_ADDR;
                        end else if (is_cmd(RX_P_DATA, CMD_ALU_OP)) begin
                            op_q <= OP_ALU; state_q <= S_GET_A;
                        end else if (is_cmd(RX_P_DATA, CMD_ALU_NOP)) begin
                            op_q <= OP_ALU; state_q <= S_GET_FUN;
                        end else if (is_cmd(RX_P_DATA, CMD_BURST_WR)) begin
                            op_q <= OP_BWR; state_q <= S_GET_ADDR;
                        end else if (is_cmd(RX_P_DATA, CMD_BURST_RD)) begin
                            op_q <= OP_BRD; state_q <= S_GET_ADDR;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    S_GET_ADDR: if (RX_D_VLD) begin
                        addr_q <= rx_addr;
                        if (op_q == OP_RD) begin
                            address_q <= rx_addr;
                            rd_en_q   <= 1'b1;
                            cnt_q     <= DATA_WIDTH'(1);
                            state_q   <= S_RD_WAIT;
                        end else if (op_q == OP_WR) begin
                            state_q <= S_GET_DATA;
                        end else begin
                            state_q <= S_GET_CNT;
                        end
                    end
                    S_GET_CNT: if (RX_D_VLD) begin
                        cnt_q <= RX_P_DATA;
                        if (RX_P_DATA == '0) begin
                            state_q <= S_IDLE;
                        end else if (op_q == OP_BWR) begin
                            state_q <= S_GET_DATA;
                        end else begin
                            address_q <= addr_q;
                            rd_en_q   <= 1'b1;
                            state_q   <= S_RD_WAIT;
                        end
                    end
                    S_GET_DATA: if (RX_D_VLD) begin
                        wr_en_q   <= 1'b1;
                        address_q <= addr_q;
                        wr_data_q <= RX_P_DATA;
                        addr_q    <= addr_d;
                        cnt_q     <= cnt_q - DATA_WIDTH'(1);
                        if (op_q == OP_WR || cnt_q == DATA_WIDTH'(1)) state_q <= S_IDLE;
                    end
                    S_GET_A: if (RX_D_VLD) begin
                        wr_en_q   <= 1'b1;
                        address_q <= '0;
                        wr_data_q <= RX_P_DATA;
                        state_q   <= S_GET_B;
                    end
                    S_GET_B: if (RX_D_VLD) begin
                        wr_en_q   <= 1'b1;
                        address_q <= ADDRESS_WIDTH'(1);
                        wr_data_q <= RX_P_DATA;
                        state_q   <= S_GET_FUN;
                    end
                    S_GET_FUN: if (RX_D_VLD) begin
                        alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
                        alu_en_q  <= 1'b1;
                        clk_en_q  <= 1'b1;
                        state_q   <= S_ALU_WAIT;
                    end
                    S_RD_REQ: begin
                        address_q <= addr_q;
                        rd_en_q   <= 1'b1;
                        state_q   <= S_RD_WAIT;
                    end
                    S_RD_WAIT: if (RdData_Valid) state_q <= S_TX_LO;
                    S_ALU_WAIT: if (OUT_VALID) begin
                        alu_hi_q <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        clk_en_q <= 1'b0;
                        state_q  <= S_TX_LO;
                    end
                    // Burst reads advance only once the previous byte has left.
                    S_TX_LO: if (tx_accepted) begin
                        if (op_q == OP_ALU) begin
                            hi_sent_q <= 1'b0;
                            state_q   <= S_TX_HI;
                        end else if (cnt_q == DATA_WIDTH'(1)) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_q - DATA_WIDTH'(1);
                            addr_q  <= addr_d;
                            state_q <= S_RD_REQ;
                        end
                    end
                    S_TX_HI: begin
                        if (tx_load) hi_sent_q <= 1'b1;
                        if (tx_accepted) begin
                            hi_sent_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    sys_ctrl_tx_slot #(.DATA_WIDTH(DATA_WIDTH)) u_tx_slot (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (tx_load),
        .data_i     (tx_data),
        .busy_i     (Busy),
        .accepted_o (tx_accepted),
        .full_o     (tx_full),
        .tx_data_o  (TX_P_DATA),
        .tx_vld_o   (TX_D_VLD)
    );

    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = alu_fun_q;
    assign CLK_EN     = clk_en_q;
    assign address    = address_q;
    assign WrEN       = wr_en_q;
    assign WrData     = wr_data_q;
    assign RdEN       = rd_en_q;
    assign clk_div_en = clk_div_en_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: a vector table of short frames plus
// hand-written sequences for reads, ALU return, timeout and mid-frame reset.
module tb_sys_ctrl_burst;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        Busy;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_EN;
    logic [3:0]  address;
    logic        WrEN;
    logic [7:0]  WrData;
    logic        RdEN;
    logic        clk_div_en;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    sys_ctrl_burst #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .Busy(Busy),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .address(address), .WrEN(WrEN), .WrData(WrData), .RdEN(RdEN),
        .clk_div_en(clk_div_en), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic        wr;
        logic        rd;
        logic        err;
        logic [3:0]  addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu_en"},     ALU_EN,     0);
        chk({tag, "_alu_fun"},    ALU_FUN,    0);
        chk({tag, "_clk_en"},     CLK_EN,     0);
        chk({tag, "_address"},    address,    0);
        chk({tag, "_wren"},       WrEN,       0);
        chk({tag, "_wrdata"},     WrData,     0);
        chk({tag, "_rden"},       RdEN,       0);
        chk({tag, "_clk_div_en"}, clk_div_en, 0);
        chk({tag, "_tx_data"},    TX_P_DATA,  0);
        chk({tag, "_tx_vld"},     TX_D_VLD,   0);
        chk({tag, "_frame_err"},  frame_err,  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_err;

        reset = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
        ALU_OUT = '0; OUT_VALID = 1'b0; Busy = 1'b0;

        // Frames: bytes, count, WrEN, RdEN, frame_err, then held address/WrData.
        vt[0] = '{32'hAA053C00, 3, 1'b1, 1'b0, 1'b0, 4'h5, 8'h3C};
        vt[1] = '{32'h55000000, 1, 1'b0, 1'b0, 1'b1, 4'h5, 8'h3C};
        vt[2] = '{32'hAA1FA500, 3, 1'b1, 1'b0, 1'b0, 4'hF, 8'hA5};
        vt[3] = '{32'h00000000, 1, 1'b0, 1'b0, 1'b1, 4'hF, 8'hA5};
        vt[4] = '{32'hEE030000, 3, 1'b0, 1'b0, 1'b0, 4'hF, 8'hA5};
        vt[5] = '{32'hAA00FF00, 3, 1'b1, 1'b0, 1'b0, 4'h0, 8'hFF};
        vt[6] = '{32'hEE090177, 4, 1'b1, 1'b0, 1'b0, 4'h9, 8'h77};
        vt[7] = '{32'hAB000000, 1, 1'b0, 1'b0, 1'b1, 4'h9, 8'h77};
        vt[8] = '{32'hEF040000, 3, 1'b0, 1'b0, 1'b0, 4'h9, 8'h77};

        // Reset state and clock-divider enable after release.
        repeat (3) tick();
        chk_zero("rst");
        reset = 1'b1;
        chk("rst_rel_clk_div_en", clk_div_en, 0);
        tick();
        chk("post_rst_clk_div_en", clk_div_en, 1);
        chk("post_rst_wren", WrEN, 0);

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                send_byte(vt[i].bytes[31-8*k -: 8]);
            end
            chk($sformatf("v%0d_wren", i),   WrEN,      vt[i].wr);
            chk($sformatf("v%0d_rden", i),   RdEN,      vt[i].rd);
            chk($sformatf("v%0d_err", i),    frame_err, vt[i].err);
            chk($sformatf("v%0d_addr", i),   address,   vt[i].addr);
            chk($sformatf("v%0d_data", i),   WrData,    vt[i].data);
            chk($sformatf("v%0d_txv", i),    TX_D_VLD,  0);
            tick();
            chk($sformatf("v%0d_wren_end", i), WrEN,      0);
            chk($sformatf("v%0d_err_end", i),  frame_err, 0);
        end

        // Burst read with wrap; register file echoes the address.
        send_byte(8'hEF); send_byte(8'h0E); send_byte(8'h03);
        for (int w = 0; w < 3; w++) begin
            logic [3:0] a;
            a = 4'(14 + w);
            chk($sformatf("brd%0d_rden", w), RdEN, 1);
            chk($sformatf("brd%0d_addr", w), address, a);
            tick();
            chk($sformatf("brd%0d_rden_pulse", w), RdEN, 0);
            RdData = {4'h0, a}; RdData_Valid = 1'b1; Busy = 1'b1;
            tick();
            RdData_Valid = 1'b0;
            chk($sformatf("brd%0d_txv", w), TX_D_VLD, 1);
            chk($sformatf("brd%0d_txd", w), TX_P_DATA, {4'h0, a});
            for (int h = 0; h < 2; h++) begin
                tick();
                chk($sformatf("brd%0d_hold_txv", w), TX_D_VLD, 1);
                chk($sformatf("brd%0d_hold_txd", w), TX_P_DATA, {4'h0, a});
                chk($sformatf("brd%0d_hold_rden", w), RdEN, 0);
            end
            Busy = 1'b0;
            tick();
            chk($sformatf("brd%0d_acc_txv", w), TX_D_VLD, 0);
            chk($sformatf("brd%0d_acc_rden", w), RdEN, 0);
            if (w < 2) tick();
        end
        tick();
        chk("brd_done_rden", RdEN, 0);
        chk("brd_done_txv", TX_D_VLD, 0);
        chk("brd_done_err", frame_err, 0);

        // ALU_OP: operand writes, ALU start, two-byte result.
        send_byte(8'hCC);
        chk("alu_cmd_wren", WrEN, 0);
        send_byte(8'h07);
        chk("alu_a_wren", WrEN, 1);
        chk("alu_a_addr", address, 0);
        chk("alu_a_data", WrData, 8'h07);
        send_byte(8'h09);
        chk("alu_b_wren", WrEN, 1);
        chk("alu_b_addr", address, 1);
        chk("alu_b_data", WrData, 8'h09);
        send_byte(8'h02);
        chk("alu_en", ALU_EN, 1);
        chk("alu_fun", ALU_FUN, 2);
        chk("alu_clk_en_rise", CLK_EN, 1);
        chk("alu_fun_wren", WrEN, 0);
        tick();
        chk("alu_en_pulse", ALU_EN, 0);
        chk("alu_clk_en_hold", CLK_EN, 1);
        OUT_VALID = 1'b1; ALU_OUT = 16'h1234;
        tick();
        OUT_VALID = 1'b0; ALU_OUT = 16'h0000;
        chk("alu_clk_en_fall", CLK_EN, 0);
        chk("alu_lo_txv", TX_D_VLD, 1);
        chk("alu_lo_txd", TX_P_DATA, 8'h34);
        tick();
        chk("alu_lo_acc", TX_D_VLD, 0);
        Busy = 1'b1;
        tick();
        chk("alu_hi_wait1", TX_D_VLD, 0);
        tick();
        chk("alu_hi_wait2", TX_D_VLD, 0);
        Busy = 1'b0;
        tick();
        chk("alu_hi_txv", TX_D_VLD, 1);
        chk("alu_hi_txd", TX_P_DATA, 8'h12);
        tick();
        chk("alu_hi_acc", TX_D_VLD, 0);
        chk("alu_fun_held", ALU_FUN, 2);

        // RX byte during RD_WAIT is dropped; the read still completes.
        send_byte(8'hBB); send_byte(8'h07);
        chk("rdw_rden", RdEN, 1);
        chk("rdw_addr", address, 7);
        send_byte(8'hAA);
        chk("rdw_drop_err", frame_err, 1);
        chk("rdw_drop_wren", WrEN, 0);
        RdData = 8'h77; RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        chk("rdw_txv", TX_D_VLD, 1);
        chk("rdw_txd", TX_P_DATA, 8'h77);
        chk("rdw_err_clr", frame_err, 0);
        tick();
        chk("rdw_acc", TX_D_VLD, 0);

        // Timeout mid-burst-write: first write kept, abort after TMO+1 idle cycles.
        send_byte(8'hEE); send_byte(8'h02); send_byte(8'h04); send_byte(8'h11);
        chk("tmo_wren", WrEN, 1);
        chk("tmo_addr", address, 2);
        chk("tmo_data", WrData, 8'h11);
        seen_err = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            tick();
            if (frame_err) seen_err = 1'b1;
        end
        chk("tmo_early_err", seen_err, 0);
        tick();
        chk("tmo_err", frame_err, 1);
        chk("tmo_err_wren", WrEN, 0);
        tick();
        chk("tmo_err_pulse", frame_err, 0);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5A);
        chk("tmo_after_wren", WrEN, 1);
        chk("tmo_after_addr", address, 3);
        chk("tmo_after_data", WrData, 8'h5A);

        // Exactly TMO idle cycles between bytes is still accepted.
        tick();
        send_byte(8'hAA); send_byte(8'h06);
        seen_err = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            tick();
            if (frame_err) seen_err = 1'b1;
        end
        chk("tmo_edge_err", seen_err, 0);
        send_byte(8'h42);
        chk("tmo_edge_wren", WrEN, 1);
        chk("tmo_edge_addr", address, 6);
        chk("tmo_edge_data", WrData, 8'h42);
        chk("tmo_edge_err2", frame_err, 0);

        // Reset in the middle of a burst write.
        tick();
        send_byte(8'hEE); send_byte(8'h08); send_byte(8'h05); send_byte(8'hAB);
        chk("mrst_wren_pre", WrEN, 1);
        chk("mrst_data_pre", WrData, 8'hAB);
        reset = 1'b0;
        #1;
        chk_zero("mrst");
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mrst_clk_div_en", clk_div_en, 1);
        chk("mrst_wren_after", WrEN, 0);
        send_byte(8'hCD);
        chk("mrst_idle_err", frame_err, 1);
        chk("mrst_idle_wren", WrEN, 0);
        tick();
        send_byte(8'hAA); send_byte(8'h09); send_byte(8'h33);
        chk("mrst_wr_wren", WrEN, 1);
        chk("mrst_wr_addr", address, 9);
        chk("mrst_wr_data", WrData, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
